// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack and its control-side users.
// Width and default depth constants plus the stack FSM state type.
package stack_pkg;

    localparam int STACK_WIDTH = 32;
    localparam int STACK_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP_RD = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack storage, DEPTH x WIDTH.
// Read data is registered: one cycle from address to rdata.
module stack_ram
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/eval_stack.sv
// Evaluation stack answering the control unit's push/pop handshake.
// Define STACK_BOUNDS_CHECK_EN for overflow/underflow protection and err.
module eval_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trigger,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE_C = (AW+1)'(1);

    state_t           state;
    logic [AW:0]      sp;
    logic [AW:0]      sp_inc;
    logic [AW:0]      sp_dec;
    logic             trig_q;
    logic             start;
    logic             ovf;
    logic             unf;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    // RESP may hand over directly to a new op for back-to-back requests
    assign start = trigger & ~trig_q & (state == IDLE || state == RESP);

`ifdef STACK_BOUNDS_CHECK_EN
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    assign ovf    = (sp == DEPTH_C);
    assign unf    = (sp == '0);
    assign sp_inc = sp + ONE_C;
    assign sp_dec = sp - ONE_C;
    assign full   = ovf;
`else
    assign ovf    = 1'b0;
    assign unf    = 1'b0;
    assign sp_inc = {1'b0, sp[AW-1:0] + ONE_C[AW-1:0]};
    assign sp_dec = {1'b0, sp[AW-1:0] - ONE_C[AW-1:0]};
    assign full   = 1'b0;
`endif

    assign ram_we   = start & push & ~ovf;
    assign ram_addr = (start & push) ? sp[AW-1:0] : sp_dec[AW-1:0];
    assign count    = sp;
    assign empty    = (sp == '0);

    stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sp     <= '0;
            trig_q <= 1'b0;
            rdata  <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            unique case (state)
                POP_RD: begin
                    rdata <= ram_rdata;
                    state <= RESP;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start && push) begin
                        state <= RESP;
                        done  <= 1'b1;
                        busy  <= 1'b1;
                        if (ovf) begin
                            err <= 1'b1;
                        end else begin
                            sp <= sp_inc;
                        end
                    end else if (start) begin
                        busy <= 1'b1;
                        if (unf) begin
                            rdata <= '0;
                            err   <= 1'b1;
                            state <= RESP;
                            done  <= 1'b1;
                        end else begin
                            sp    <= sp_dec;
                            state <= POP_RD;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eval_stack.sv
// Directed bench for eval_stack with a queue-level reference model.
// Works with or without STACK_BOUNDS_CHECK_EN; uses a 4-entry stack.
module tb_eval_stack;
    import stack_pkg::*;

    localparam int D  = 4;
    localparam int W  = STACK_WIDTH;
    localparam int CW = $clog2(D) + 1;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          trigger;
    logic          push;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          done;
    logic          busy;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          err;

    eval_stack #(
        .DEPTH (D),
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .push    (push),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .busy    (busy),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total    = 0;
    int passed   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: no done within bound", name);
    endtask

    // Reference model: an array stack plus remaining-busy-cycles counter
    logic [W-1:0] m_mem [D];
    int           m_sp;
    bit           m_prev;
    int           m_left;
    bit           m_pend;
    bit           m_can;
    logic [W-1:0] m_pval;
    logic [W-1:0] m_rdata;
    bit           m_err;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_sp = 0; m_prev = 0; m_left = 0; m_pend = 0;
                m_rdata = '0; m_err = 0;
            end else begin
                m_can = (m_left <= 1);
                if (m_left > 0) m_left--;
                if (trigger && !m_prev && m_can) begin
                    if (push) begin
                        if (BC && m_sp == D) m_err = 1;
                        else begin
                            m_mem[m_sp % D] = wdata;
                            m_sp = BC ? m_sp + 1 : (m_sp + 1) % D;
                        end
                        m_left = 1;
                    end else if (BC && m_sp == 0) begin
                        m_err = 1; m_pval = '0; m_pend = 1; m_left = 1;
                    end else begin
                        m_sp = BC ? m_sp - 1 : (m_sp + D - 1) % D;
                        m_pval = m_mem[m_sp]; m_pend = 1; m_left = 2;
                    end
                end
                if (m_left == 1 && m_pend) begin
                    m_rdata = m_pval; m_pend = 0;
                end
                m_prev = trigger;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rst_n) begin
                chk("done",  32'(done),  32'(m_left == 1));
                chk("busy",  32'(busy),  32'(m_left > 0));
                chk("count", 32'(count), 32'(m_sp));
                chk("empty", 32'(empty), 32'(m_sp == 0));
                chk("full",  32'(full),  32'(BC && m_sp == D));
                chk("err",   32'(err),   32'(m_err));
                chk("rdata", rdata, m_rdata);
            end
        end
    end

    task automatic wait_done(input string name, output logic [31:0] val,
                             output int lat);
        bit got;
        got = 0; lat = 0; val = '0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1; lat = i; val = rdata;
            end
        end
        if (!got) timeout(name);
    endtask

    task automatic op(input bit p, input logic [31:0] w,
                      output logic [31:0] val, output int lat);
        @(posedge clk); #1;
        trigger = 1'b1; push = p; wdata = w;
        wait_done(p ? "push" : "pop", val, lat);
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; trigger = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] v;
    logic [31:0] opa;
    logic [31:0] opb;
    int          lat;
    int          dc0;

    initial begin
        rst_n = 1'b0; trigger = 1'b0; push = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err",   32'(err),   0);

        op(1'b1, 32'h5, v, lat);
        chk("push_lat", 32'(lat), 2);
        @(negedge clk);
        chk("push_count", 32'(count), 1);
        chk("push_empty", 32'(empty), 0);

        do_reset();
        op(1'b1, 32'h11, v, lat);
        op(1'b1, 32'h22, v, lat);
        op(1'b1, 32'h33, v, lat);
        op(1'b0, 0, v, lat);
        chk("pop1", v, 32'h33);
        chk("pop_lat", 32'(lat), 3);
        op(1'b0, 0, v, lat);
        chk("pop2", v, 32'h22);
        op(1'b0, 0, v, lat);
        chk("pop3", v, 32'h11);
        @(negedge clk);
        chk("lifo_empty", 32'(empty), 1);

        do_reset();
        dc0 = done_cnt;
        @(posedge clk); #1;
        trigger = 1'b1; push = 1'b1; wdata = 32'h7;
        repeat (5) @(posedge clk);
        #1 trigger = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold_dones", 32'(done_cnt - dc0), 1);
        chk("hold_count", 32'(count), 1);

        do_reset();
        op(1'b1, 32'hA, v, lat);
        op(1'b1, 32'hB, v, lat);
        @(posedge clk); #1;
        trigger = 1'b1; push = 1'b0;
        @(posedge clk); #1;
        trigger = 1'b0;
        wait_done("b2b_first", opb, lat);
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        wait_done("b2b_second", opa, lat);
        chk("operand_b", opb, 32'hB);
        chk("operand_a", opa, 32'hA);
        @(negedge clk);
        chk("b2b_empty", 32'(empty), 1);

        do_reset();
        for (int i = 1; i <= 5; i++) begin
            op(1'b1, 32'h100 + i, v, lat);
            @(negedge clk);
            if (BC && i == 4) chk("full_at_4", 32'(full), 1);
        end
        if (BC) begin
            chk("ovf_err",   32'(err),   1);
            chk("ovf_count", 32'(count), 4);
            for (int i = 4; i >= 0; i--) begin
                op(1'b0, 0, v, lat);
                chk("bc_pop", v, (i == 0) ? 32'h0 : 32'h100 + i);
                chk("bc_lat", 32'(lat), (i == 0) ? 2 : 3);
            end
            @(negedge clk);
            chk("unf_err", 32'(err), 1);
        end else begin
            chk("wrap_count", 32'(count), 1);
            chk("wrap_full",  32'(full),  0);
            op(1'b0, 0, v, lat);
            chk("wrap_pop", v, 32'h105);
            op(1'b0, 0, v, lat);
            chk("stale_pop", v, 32'h104);
            @(negedge clk);
            chk("stale_count", 32'(count), 3);
            chk("wrap_err",    32'(err),   0);
        end

        do_reset();
        op(1'b1, 32'h1, v, lat);
        op(1'b1, 32'h2, v, lat);
        @(posedge clk); #1;
        trigger = 1'b1; push = 1'b0;
        @(posedge clk); #1;
        trigger = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        dc0 = done_cnt;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_dones", 32'(done_cnt - dc0), 0);
        chk("abort_count", 32'(count), 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_busy",  32'(busy),  0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
